// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the 4x4 keypad scanner.
//   - scan_state_t : scanner FSM states
//   - KEYMAP       : hex code for each (row, col) key position
//   - COL_DRIVE    : active-low column drive pattern per column index
//   - row_index()  : lowest-index low row plus an any-low flag
//   - multi_low()  : true when more than one row reads low
//   No ports (package). The optional feature macro KEYPAD_GHOST_REJECT_EN
//   is consumed by keypad_scan_debounce, not here.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    // Indexed [row][col].
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    localparam logic [3:0] COL_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef struct packed {
        logic       any;
        logic [1:0] idx;
    } row_hit_t;

    // Rows are active-low; scanning from the top down leaves the lowest
    // index in hit.idx when several rows are low.
    function automatic row_hit_t row_index(input logic [3:0] rows);
        row_hit_t hit;
        hit.any = 1'b0;
        hit.idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                hit.any = 1'b1;
                hit.idx = 2'(i);
            end
        end
        return hit;
    endfunction

    function automatic logic multi_low(input logic [3:0] rows);
        return ($countones(~rows) > 1);
    endfunction

endpackage

// File: rtl/row_sync.sv
// row_sync
//   Two-flop synchronizer for asynchronous inputs. Resets to all-ones so
//   active-low keypad rows read as "nothing pressed" out of reset.
//   Ports:
//     clk  in          clock
//     rst  in          synchronous active-high reset
//     din  in  WIDTH   asynchronous input
//     dout out WIDTH   synchronized output (2 clk latency)
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg[gi] <= 1'b1;
                    sync2_reg[gi] <= 1'b1;
                end else begin
                    sync1_reg[gi] <= din[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    assign dout = sync2_reg;

endmodule

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces
//   the rows, and reports one held key as a hex code with a level valid.
//   Optional feature macro: KEYPAD_GHOST_REJECT_EN (multi-row readings are
//   treated as "no key" while acquiring, and as "still held" while held).
//   Ports:
//     clk        in   1  system clock
//     rst        in   1  synchronous active-high reset
//     row_in     in   4  keypad rows, active-low, asynchronous
//     col_out    out  4  column drive, active-low, one column low at a time
//     key_code   out  4  hex code of the accepted key (held after release)
//     key_valid  out  1  high while the accepted key is held
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int TICK_W = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(DEBOUNCE_TICKS);

    logic [3:0] rows_s;

    row_sync #(.WIDTH(4)) u_row_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (row_in),
        .dout (rows_s)
    );

    // Scan tick divider.
    logic [TICK_W-1:0] tick_cnt_reg;
    logic              tick;

    assign tick = (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
        end
    end

    // FSM state.
    scan_state_t      state_reg,     state_next;
    logic [1:0]       col_reg,       col_next;
    logic [1:0]       row_reg,       row_next;
    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    logic [3:0]       key_code_reg,  key_code_next;
    logic             key_valid_reg, key_valid_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SCAN;
            col_reg       <= 2'd0;
            row_reg       <= 2'd0;
            cnt_reg       <= '0;
            key_code_reg  <= 4'h0;
            key_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_reg       <= col_next;
            row_reg       <= row_next;
            cnt_reg       <= cnt_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
        end
    end

    // Row qualifiers for each phase. The latched row is checked directly;
    // the ghost option only changes how multi-row readings are judged.
    row_hit_t hit;
    logic     latched_low;
    logic     scan_any;
    logic     acquire_low;
    logic     held_low;

    assign hit         = row_index(rows_s);
    assign latched_low = ~rows_s[row_reg];

`ifdef KEYPAD_GHOST_REJECT_EN
    logic multi;
    assign multi       = multi_low(rows_s);
    assign scan_any    = hit.any & ~multi;
    assign acquire_low = latched_low & ~multi;
    assign held_low    = latched_low | multi;
`else
    assign scan_any    = hit.any;
    assign acquire_low = latched_low;
    assign held_low    = latched_low;
`endif

    always_comb begin
        state_next     = state_reg;
        col_next       = col_reg;
        row_next       = row_reg;
        cnt_next       = cnt_reg;
        key_code_next  = key_code_reg;
        key_valid_next = key_valid_reg;

        if (tick) begin
            case (state_reg)
                SCAN: begin
                    if (scan_any) begin
                        row_next   = hit.idx;
                        cnt_next   = CNT_W'(1);
                        state_next = DEBOUNCE;
                    end else begin
                        col_next = col_reg + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (acquire_low) begin
                        // The detection tick counts as the first stable
                        // sample; acceptance lands on the tick after the
                        // count has saturated.
                        if (cnt_reg >= CNT_SAT) begin
                            state_next     = HELD;
                            key_code_next  = KEYMAP[row_reg][col_reg];
                            key_valid_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        state_next = SCAN;
                        col_next   = col_reg + 2'd1;
                    end
                end
                HELD: begin
                    if (!held_low) begin
                        cnt_next   = CNT_W'(1);
                        state_next = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!latched_low) begin
                        if (cnt_reg >= CNT_SAT) begin
                            state_next     = SCAN;
                            key_valid_next = 1'b0;
                            col_next       = col_reg + 2'd1;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end else begin
                        state_next = HELD;
                    end
                end
                default: begin
                    state_next = SCAN;
                end
            endcase
        end
    end

    assign col_out   = COL_DRIVE[col_reg];
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce
//   Scoreboard bench for keypad_scan_debounce with SCAN_DIV=4 and
//   DEBOUNCE_TICKS=3. Stimulus presses keys on a modelled matrix and pushes
//   expected key_valid edges (with key_code) into a queue; a monitor pops
//   and compares on every key_valid edge outside reset.
//   Define KEYPAD_GHOST_REJECT_EN to also exercise ghost rejection.
module tb_keypad_scan_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;

    // pressed[row][col] = 1 when that key is down.
    logic [3:0] pressed [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic [3:0] code;
    } evt_t;

    evt_t exp_q[$];

    always #5 clk = ~clk;

    keypad_scan_debounce #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    // Matrix model: a row reads low when a pressed key sits in a driven column.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (|(pressed[r] & ~col_out)) row_in[r] = 1'b0;
        end
    end

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic check_n(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic v, input logic [3:0] code);
        evt_t e;
        e.valid = v;
        e.code  = code;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input logic want, input int limit, input string name);
        int n = 0;
        while (key_valid !== want && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (key_valid !== want) begin
            errors++;
            $display("FAIL %s: key_valid=%b expected %b within %0d cycles", name, key_valid, want, limit);
        end else begin
            $display("ok   %s: key_valid=%b after %0d cycles", name, key_valid, n);
        end
    endtask

    task automatic wait_col(input logic [3:0] want, input int limit, input string name);
        int n = 0;
        while (col_out !== want && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (col_out !== want) begin
            errors++;
            $display("FAIL %s: col_out=%b expected %b within %0d cycles", name, col_out, want, limit);
        end else begin
            $display("ok   %s: col_out=%b", name, col_out);
        end
    endtask

    // Monitor: every key_valid edge outside reset is one transaction.
    initial begin
        logic prev;
        evt_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev = key_valid;
            end else if (key_valid !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL edge_unexpected: key_valid=%b key_code=%h expected no edge", key_valid, key_code);
                end else begin
                    e = exp_q.pop_front();
                    if (key_valid !== e.valid || key_code !== e.code) begin
                        errors++;
                        $display("FAIL edge: key_valid=%b key_code=%h expected key_valid=%b key_code=%h",
                                 key_valid, key_code, e.valid, e.code);
                    end else begin
                        $display("ok   edge: key_valid=%b key_code=%h", key_valid, key_code);
                    end
                end
                prev = key_valid;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] c0;
        logic       stay;
        int         n;

        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;

        // Reset state and idle rotation (one column per 4 clocks).
        rst = 1'b1;
        cycles(2);
        check4("reset_col", col_out, 4'b1110);
        check4("reset_valid", {3'b0, key_valid}, 4'h0);
        check4("reset_code", key_code, 4'h0);
        rst = 1'b0;
        cycles(4); check4("rotate_1", col_out, 4'b1101);
        cycles(4); check4("rotate_2", col_out, 4'b1011);
        cycles(4); check4("rotate_3", col_out, 4'b0111);
        cycles(4); check4("rotate_0", col_out, 4'b1110);

        // Clean press of '6' (r1/c2): valid rises (DT+1)*SCAN_DIV clocks
        // after column 2 becomes active (2 sync + tick alignment + 3 ticks).
        push(1'b1, 4'h6);
        push(1'b0, 4'h6);
        pressed[1][2] = 1'b1;
        wait_col(4'b1011, 20, "press6_col");
        n = 0;
        while (!key_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_n("press6_latency", n, 16);
        cycles(20);
        check4("press6_frozen_col", col_out, 4'b1011);
        check4("press6_code", key_code, 4'h6);
        pressed[1][2] = 1'b0;
        wait_valid(1'b0, 40, "release6");

        // Bounce: '7' (r2/c0) low for one tick, then for two ticks.
        wait_col(4'b1110, 20, "bounce1_col");
        pressed[2][0] = 1'b1;
        cycles(4);
        pressed[2][0] = 1'b0;
        cycles(20);
        wait_col(4'b1110, 20, "bounce2_col");
        pressed[2][0] = 1'b1;
        cycles(8);
        pressed[2][0] = 1'b0;
        cycles(20);
        check4("bounce_valid", {3'b0, key_valid}, 4'h0);
        c0 = col_out;
        cycles(4);
        check_n("bounce_scan_resumes", int'(col_out != c0), 1);

        // Release bounce on '0' (r3/c1): one high tick then re-press.
        push(1'b1, 4'h0);
        pressed[3][1] = 1'b1;
        wait_valid(1'b1, 60, "press0");
        cycles(8);
        pressed[3][1] = 1'b0;
        cycles(4);
        pressed[3][1] = 1'b1;
        stay = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!key_valid) stay = 1'b0;
        end
        check4("release_bounce_valid", {3'b0, stay}, 4'h1);
        check4("release_bounce_code", key_code, 4'h0);
        push(1'b0, 4'h0);
        pressed[3][1] = 1'b0;
        wait_valid(1'b0, 60, "release0");

        // Rollover: 'A' (r0/c3) locked; '5' (r1/c1) reported after A releases.
        push(1'b1, 4'hA);
        pressed[0][3] = 1'b1;
        wait_valid(1'b1, 60, "pressA");
        pressed[1][1] = 1'b1;
        cycles(30);
        check4("rollover_code_A", key_code, 4'hA);
        check4("rollover_col", col_out, 4'b0111);
        push(1'b0, 4'hA);
        push(1'b1, 4'h5);
        pressed[0][3] = 1'b0;
        wait_valid(1'b0, 60, "releaseA");
        wait_valid(1'b1, 80, "press5");
        check4("rollover_code_5", key_code, 4'h5);
        push(1'b0, 4'h5);
        pressed[1][1] = 1'b0;
        wait_valid(1'b0, 60, "release5");

        // Reset while '9' (r2/c2) is held, then normal re-acquisition.
        push(1'b1, 4'h9);
        pressed[2][2] = 1'b1;
        wait_valid(1'b1, 60, "press9");
        rst = 1'b1;
        cycles(1);
        check4("midreset_valid", {3'b0, key_valid}, 4'h0);
        check4("midreset_col", col_out, 4'b1110);
        check4("midreset_code", key_code, 4'h0);
        push(1'b1, 4'h9);
        push(1'b0, 4'h9);
        rst = 1'b0;
        wait_valid(1'b1, 80, "reacquire9");
        check4("reacquire9_code", key_code, 4'h9);
        pressed[2][2] = 1'b0;
        wait_valid(1'b0, 60, "release9");

`ifdef KEYPAD_GHOST_REJECT_EN
        // Ghost: r0 and r2 low together in column 0 never yield a key.
        wait_col(4'b1110, 20, "ghost_col");
        pressed[0][0] = 1'b1;
        pressed[2][0] = 1'b1;
        cycles(60);
        check4("ghost_valid", {3'b0, key_valid}, 4'h0);
        pressed[0][0] = 1'b0;
        pressed[2][0] = 1'b0;
        cycles(10);
`endif

        cycles(10);
        check_n("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Drives the 4x4 matrix keypad columns one at a time and reads the rows.
- Synchronizes and debounces the row inputs, then reports one held key as a 4-bit hex code with a level-valid flag.
- Producer side of the key_code/key_valid interface consumed by the one-shot capture logic in the keypad display top; runs from the 12 MHz internal oscillator clock.

Parameters:
- SCAN_DIV, 12000: clock cycles per scan tick. Default gives 1 kHz at 12 MHz. Minimum 2.
- DEBOUNCE_TICKS, 20: consecutive stable scan ticks needed to accept a press or a release. Minimum 1.

Ports:
- clk  in  1  system clock (12 MHz).
- rst  in  1  synchronous, active-high reset.
- row_in  in  4  keypad rows; active-low; asynchronous to clk.
- col_out  out  4  keypad column drive; active-low, one-hot-zero.
- key_code  out  4  hex value of the accepted key.
- key_valid  out  1  high while the accepted key is held, including release debounce.

Behaviour:
- Reset values:
  - rst is sampled on posedge clk.
  - col_out=4'b1110 (column 0), key_code=4'h0, key_valid=0, state=SCAN.
  - Tick counter=0, debounce counter=0, synchronizer flops=4'b1111.
- Row sync: row_in passes through 2 flops to give rows_s. All decisions use rows_s, and only on a tick.
- Tick: a 1-cycle pulse when the divider counter reaches SCAN_DIV-1; the counter then wraps to 0.
- Key map, by (row, col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Multiple rows low in one column: the lowest-index row wins.
- States (all transitions occur on a tick only):
  - SCAN:
    - If any rows_s bit is low, latch the row and col, set cnt=1, go to DEBOUNCE. The column stays frozen.
    - Otherwise rotate col_out to the next column (3 wraps to 0).
  - DEBOUNCE:
    - If the latched row is still low: cnt++. When cnt reaches DEBOUNCE_TICKS, go to HELD, set key_code=map(row,col) and key_valid=1 in the same cycle.
    - If the latched row is high: go to SCAN and rotate the column. No output change.
    - With DEBOUNCE_TICKS=1, HELD is entered on the next tick after detection.
  - HELD:
    - Column stays frozen.
    - If the latched row goes high: cnt=1, go to RELEASE.
    - Presses of other rows or columns are ignored.
  - RELEASE:
    - If the latched row is still high: cnt++. When cnt reaches DEBOUNCE_TICKS, go to SCAN, key_valid=0, and the column rotates.
    - If the latched row goes low again: go to HELD. key_valid stays 1.
- key_code holds its last value after release. It changes only on entry to HELD.
- Latency: key_valid rises exactly DEBOUNCE_TICKS ticks after the first tick that samples the press.
- Rollover: the first accepted key is locked. A second key goes unreported until the first is released and SCAN resumes.
- Reset mid-operation: all state returns to reset values on the next clk edge. key_valid drops even while a key is held.
- Counters never overflow: cnt saturates logic at DEBOUNCE_TICKS, with width $clog2(DEBOUNCE_TICKS+1).

Optional Feature:
- Macro: KEYPAD_GHOST_REJECT_EN.
- When defined:
  - In SCAN and DEBOUNCE, more than one low bit in rows_s counts as "no key": SCAN rotates; DEBOUNCE returns to SCAN.
  - In HELD, a multi-row reading is treated as the latched row still low.
- When undefined: the lowest-index low row wins, as above.

Decomposition:
- Package keypad_pkg:
  - State enum scan_state_t {SCAN, DEBOUNCE, HELD, RELEASE}.
  - KEYMAP constant array [4][4] of logic[3:0].
  - Column drive constant for col index → active-low pattern.
  - Function row_index returning the lowest low row and an any-low flag.
- Sub-module row_sync: parameterized-width 2-flop synchronizer with synchronous active-high reset to all-ones.

Test Plan (SCAN_DIV=4, DEBOUNCE_TICKS=3 unless noted):
- Reset check: assert rst 2 cycles -> col_out=1110, key_valid=0, key_code=0. With no keys, col_out rotates 1110→1101→1011→0111→1110, once every 4 clocks.
- Clean press of row 1 / col 2 ('6'), held 40 cycles -> key_valid rises 3 ticks after detection with key_code=4'h6. col_out frozen at 1011 while held. After release, key_valid falls after 3 high ticks.
- Bounce: row pulses low for 1 tick then high, repeated -> key_valid stays 0 and scanning continues.
- Release bounce: after '0' (row 3 / col 1) is accepted, release for 1 tick, then re-press -> key_valid stays 1 throughout and key_code=4'h0.
- Rollover: hold 'A' (r0/c3), then press '5', then release 'A' while holding '5' -> 'A' reported first. After release debounce, '5' is accepted (key_code=4'h5).
- Reset mid-HELD: assert rst while '9' is held -> next clock key_valid=0, col_out=1110. After reset, '9' is re-acquired via normal debounce. With KEYPAD_GHOST_REJECT_EN defined, rows r0+r2 low in col 0 -> no key_valid.
